// File: rtl/idu_queue.sv
// Decode stage between IFU and EXU: classifies RV32I/Zicsr/privileged words,
// builds the immediate, and buffers decoded entries in a DEPTH-entry FIFO.
module idu_queue #(
    parameter int DEPTH    = 2,
    parameter int PC_W     = 32,
    parameter int CSR_FULL = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst,
    input  logic [PC_W-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [3:0]                 out_class,
    output logic [2:0]                 out_func3,
    output logic                       out_alt,
    output logic [4:0]                 out_rd,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [31:0]                out_imm,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Storage rounded up to a power of two so the pointer never indexes past the array.
    localparam int MEM_N = 1 << PTR_W;

    localparam logic [3:0] CLS_LOAD    = 4'd0;
    localparam logic [3:0] CLS_OPIMM   = 4'd1;
    localparam logic [3:0] CLS_AUIPC   = 4'd2;
    localparam logic [3:0] CLS_STORE   = 4'd3;
    localparam logic [3:0] CLS_OP      = 4'd4;
    localparam logic [3:0] CLS_LUI     = 4'd5;
    localparam logic [3:0] CLS_BRANCH  = 4'd6;
    localparam logic [3:0] CLS_JALR    = 4'd7;
    localparam logic [3:0] CLS_JAL     = 4'd8;
    localparam logic [3:0] CLS_CSR     = 4'd9;
    localparam logic [3:0] CLS_ECALL   = 4'd10;
    localparam logic [3:0] CLS_MRET    = 4'd11;
    localparam logic [3:0] CLS_EBREAK  = 4'd12;
    localparam logic [3:0] CLS_ILLEGAL = 4'd15;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [3:0]      cls;
        logic [2:0]      func3;
        logic            alt;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [31:0]     imm;
    } entry_t;

    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    entry_t           r_mem [MEM_N];

    logic [3:0]  w_cls;
    logic [31:0] w_imm;
    logic        w_alt;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic        w_push;
    logic        w_pop;
    entry_t      w_entry;
    entry_t      w_head;
    logic [PTR_W-1:0] w_wr_ptr_inc;
    logic [PTR_W-1:0] w_rd_ptr_inc;

    assign w_f3    = in_inst[14:12];
    assign w_imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
    assign w_imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign w_imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                      in_inst[11:8], 1'b0};
    assign w_imm_u = {in_inst[31:12], 12'b0};
    assign w_imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                      in_inst[30:21], 1'b0};

    always_comb begin
        w_cls = CLS_ILLEGAL;
        w_imm = '0;
        w_alt = 1'b0;
        if (in_inst[1:0] == 2'b11) begin
            case (in_inst[6:2])
                5'b00000: begin
                    if (w_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
                        w_cls = CLS_LOAD;
                        w_imm = w_imm_i;
                    end
                end
                5'b00100: begin
                    w_cls = CLS_OPIMM;
                    w_imm = w_imm_i;
                    // Only the shift-immediates carry the alternate-op bit.
                    w_alt = (w_f3 == 3'd1 || w_f3 == 3'd5) ? in_inst[30] : 1'b0;
                end
                5'b00101: begin
                    w_cls = CLS_AUIPC;
                    w_imm = w_imm_u;
                end
                5'b01000: begin
                    if (w_f3 inside {3'd0, 3'd1, 3'd2}) begin
                        w_cls = CLS_STORE;
                        w_imm = w_imm_s;
                    end
                end
                5'b01100: begin
                    w_cls = CLS_OP;
                    w_alt = in_inst[30];
                end
                5'b01101: begin
                    w_cls = CLS_LUI;
                    w_imm = w_imm_u;
                end
                5'b11000: begin
                    if (w_f3 != 3'd2 && w_f3 != 3'd3) begin
                        w_cls = CLS_BRANCH;
                        w_imm = w_imm_b;
                    end
                end
                5'b11001: begin
                    w_cls = CLS_JALR;
                    w_imm = w_imm_i;
                end
                5'b11011: begin
                    w_cls = CLS_JAL;
                    w_imm = w_imm_j;
                end
                5'b11100: begin
                    if (w_f3 == 3'd0) begin
                        if (in_inst[20])      w_cls = CLS_EBREAK;
                        else if (in_inst[21]) w_cls = CLS_MRET;
                        else                  w_cls = CLS_ECALL;
                    end else if (w_f3 == 3'd1 || w_f3 == 3'd2) begin
                        w_cls = CLS_CSR;
                        w_imm = w_imm_i;
                    end else if (CSR_FULL != 0 && w_f3 != 3'd4) begin
                        w_cls = CLS_CSR;
                        w_imm = w_imm_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_entry       = '0;
        w_entry.pc    = in_pc;
        w_entry.cls   = w_cls;
        w_entry.func3 = w_f3;
        w_entry.alt   = w_alt;
        w_entry.rd    = in_inst[11:7];
        w_entry.rs1   = in_inst[19:15];
        w_entry.rs2   = in_inst[24:20];
        w_entry.imm   = w_imm;
    end

    assign in_ready  = (r_count != CNT_W'(DEPTH)) && !flush;
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign w_wr_ptr_inc = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
    assign w_rd_ptr_inc = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= w_wr_ptr_inc;
            if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < MEM_N; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_mem[gi] <= '0;
                end else if (w_push && r_wr_ptr == PTR_W'(gi)) begin
                    r_mem[gi] <= w_entry;
                end
            end
        end
    endgenerate

    assign w_head      = r_mem[r_rd_ptr];
    assign out_pc      = w_head.pc;
    assign out_class   = w_head.cls;
    assign out_func3   = w_head.func3;
    assign out_alt     = w_head.alt;
    assign out_rd      = w_head.rd;
    assign out_rs1     = w_head.rs1;
    assign out_rs2     = w_head.rs2;
    assign out_imm     = w_head.imm;
    assign out_illegal = (w_head.cls == CLS_ILLEGAL);
    assign count       = r_count;

endmodule

// File: tb/tb_idu_queue.sv
// Directed bench for idu_queue: decode tables, backpressure, flush and async reset.
module tb_idu_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_ready;

    logic        in_ready, out_valid, out_alt, out_illegal;
    logic [31:0] out_pc, out_imm;
    logic [3:0]  out_class;
    logic [2:0]  out_func3;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [1:0]  count;

    logic        f_in_ready, f_out_valid, f_out_alt, f_out_illegal;
    logic [31:0] f_out_pc, f_out_imm;
    logic [3:0]  f_out_class;
    logic [2:0]  f_out_func3;
    logic [4:0]  f_out_rd, f_out_rs1, f_out_rs2;
    logic [0:0]  f_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    idu_queue #(.DEPTH(2), .PC_W(32), .CSR_FULL(0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_class(out_class), .out_func3(out_func3), .out_alt(out_alt),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_illegal(out_illegal), .count(count)
    );

    idu_queue #(.DEPTH(1), .PC_W(32), .CSR_FULL(1)) dut_full (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(f_in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(f_out_valid), .out_ready(out_ready), .out_pc(f_out_pc),
        .out_class(f_out_class), .out_func3(f_out_func3), .out_alt(f_out_alt),
        .out_rd(f_out_rd), .out_rs1(f_out_rs1), .out_rs2(f_out_rs2),
        .out_imm(f_out_imm), .out_illegal(f_out_illegal), .count(f_count)
    );

    // Immediate / class table: jal, bne, lui, sw, sub, srai
    logic [31:0] imm_inst [6] = '{32'h0040006F, 32'hFE209EE3, 32'h123450B7,
                                  32'h00112423, 32'h402081B3, 32'h4010D093};
    logic [3:0]  imm_cls  [6] = '{4'd8, 4'd6, 4'd5, 4'd3, 4'd4, 4'd1};
    logic [31:0] imm_exp  [6] = '{32'h4, 32'hFFFFFFFC, 32'h12345000,
                                  32'h8, 32'h0, 32'h401};
    logic        imm_alt  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // System / illegal table: zero word, ecall, ebreak, mret, csrrc, load func3=3
    logic [31:0] sys_inst [6] = '{32'h00000000, 32'h00000073, 32'h00100073,
                                  32'h30200073, 32'h3000B073, 32'h00003003};
    logic [3:0]  sys_cls  [6] = '{4'd15, 4'd10, 4'd12, 4'd11, 4'd15, 4'd15};
    logic [3:0]  sys_full [6] = '{4'd15, 4'd10, 4'd12, 4'd11, 4'd9, 4'd15};

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
        #12;
        n_checks++;
        if (out_valid !== 1'b0 || count !== 2'd0) begin
            n_fail++; $display("FAIL reset_valid_count got v=%0b c=%0d want v=0 c=0", out_valid, count);
        end
        n_checks++;
        if (out_class !== 4'd0 || out_imm !== 32'd0 || out_pc !== 32'd0 || out_illegal !== 1'b0) begin
            n_fail++; $display("FAIL reset_data got cls=%0d imm=%h pc=%h ill=%0b want 0", out_class, out_imm, out_pc, out_illegal);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready);
        end
        $display("reset: checked");
    endtask

    task automatic test_single_decode();
        @(negedge clk);
        in_valid = 1'b1; in_inst = 32'hFFF10093; in_pc = 32'h80000000;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_class !== 4'd1 || out_rd !== 5'd1 || out_rs1 !== 5'd2) begin
            n_fail++; $display("FAIL addi_fields got v=%0b cls=%0d rd=%0d rs1=%0d want 1 1 1 2", out_valid, out_class, out_rd, out_rs1);
        end
        n_checks++;
        if (out_imm !== 32'hFFFFFFFF || out_pc !== 32'h80000000 || out_alt !== 1'b0 || out_func3 !== 3'd0) begin
            n_fail++; $display("FAIL addi_imm_pc got imm=%h pc=%h alt=%0b f3=%0d want ffffffff 80000000 0 0", out_imm, out_pc, out_alt, out_func3);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (count !== 2'd0) begin
            n_fail++; $display("FAIL addi_pop_count got %0d want 0", count);
        end
        $display("single decode: inst=fff10093 cls=%0d imm=%h", out_class, out_imm);
    endtask

    task automatic test_immediates();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_inst = imm_inst[i]; in_pc = 32'h1000 + 32'(i * 4);
            @(negedge clk);
            in_valid = 1'b0;
            n_checks++;
            if (out_valid !== 1'b1 || out_class !== imm_cls[i] || out_imm !== imm_exp[i] || out_alt !== imm_alt[i]) begin
                n_fail++;
                $display("FAIL imm[%0d] got v=%0b cls=%0d imm=%h alt=%0b want v=1 cls=%0d imm=%h alt=%0b",
                         i, out_valid, out_class, out_imm, out_alt, imm_cls[i], imm_exp[i], imm_alt[i]);
            end
            if (i == 3) begin
                n_checks++;
                if (out_rs1 !== 5'd2 || out_rs2 !== 5'd1 || out_func3 !== 3'd2) begin
                    n_fail++; $display("FAIL sw_regs got rs1=%0d rs2=%0d f3=%0d want 2 1 2", out_rs1, out_rs2, out_func3);
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            $display("imm: inst=%h cls=%0d imm=%h", imm_inst[i], out_class, out_imm);
        end
    endtask

    task automatic test_system();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_inst = sys_inst[i]; in_pc = 32'h2000 + 32'(i * 4);
            @(negedge clk);
            in_valid = 1'b0;
            n_checks++;
            if (out_class !== sys_cls[i] || out_illegal !== (sys_cls[i] == 4'd15) || out_imm !== 32'd0) begin
                n_fail++;
                $display("FAIL sys[%0d] got cls=%0d ill=%0b imm=%h want cls=%0d imm=0", i, out_class, out_illegal, out_imm, sys_cls[i]);
            end
            n_checks++;
            if (f_out_valid !== 1'b1 || f_out_class !== sys_full[i]) begin
                n_fail++;
                $display("FAIL sys_full[%0d] got v=%0b cls=%0d want v=1 cls=%0d", i, f_out_valid, f_out_class, sys_full[i]);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            $display("sys: inst=%h cls=%0d full_cls=%0d", sys_inst[i], out_class, f_out_class);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 32'h100;
        @(negedge clk);
        in_pc = 32'h104;
        @(negedge clk);
        in_pc = 32'h108;
        @(negedge clk);
        #1;
        n_checks++;
        if (count !== 2'd2 || in_ready !== 1'b0 || out_pc !== 32'h100) begin
            n_fail++; $display("FAIL bp_full got c=%0d rdy=%0b pc=%h want 2 0 100", count, in_ready, out_pc);
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_no_ready_path got rdy=%0b want 0", in_ready);
        end
        @(negedge clk);
        n_checks++;
        if (count !== 2'd1 || out_pc !== 32'h104 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_pop1 got c=%0d pc=%h rdy=%0b want 1 104 1", count, out_pc, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (count !== 2'd1 || out_pc !== 32'h108) begin
            n_fail++; $display("FAIL bp_pop2 got c=%0d pc=%h want 1 108", count, out_pc);
        end
        @(negedge clk);
        n_checks++;
        if (count !== 2'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_drain got c=%0d v=%0b want 0 0", count, out_valid);
        end
        out_ready = 1'b0;
        @(negedge clk);
        $display("backpressure: drained, count=%0d", count);
    endtask

    task automatic test_flush();
        @(negedge clk);
        in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 32'h300;
        @(negedge clk);
        in_pc = 32'h304;
        @(negedge clk);
        flush = 1'b1; in_pc = 32'h200; #1;
        n_checks++;
        if (count !== 2'd2 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_cycle got c=%0d rdy=%0b want 2 0", count, in_ready);
        end
        @(negedge clk);
        flush = 1'b0; #1;
        n_checks++;
        if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_after got c=%0d v=%0b rdy=%0b want 0 0 1", count, out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (count !== 2'd1 || out_pc !== 32'h200) begin
            n_fail++; $display("FAIL flush_refill got c=%0d pc=%h want 1 200", count, out_pc);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        $display("flush: count=%0d", count);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 32'h400;
        @(negedge clk);
        in_pc = 32'h404;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (count !== 2'd2) begin
            n_fail++; $display("FAIL async_prefill got c=%0d want 2", count);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || count !== 2'd0 || out_pc !== 32'd0) begin
            n_fail++; $display("FAIL async_reset got v=%0b c=%0d pc=%h want 0 0 0", out_valid, count, out_pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("async reset: count=%0d", count);
    endtask

    initial begin
        test_reset();
        test_single_decode();
        test_immediates();
        test_system();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
